wb_commit: RTL and testbench

Write-back commit unit for the RV32I core: the writer side of the register file. Accepts results from the single-cycle ALU path and the multi-cycle load path, arbitrates them into one registered register-file write port (`write_en`/`write_reg`/`write_data`), and keeps a per-register pending-write scoreboard. The decode stage uses this scoreboard to stall on read-after-write hazards.

---
 rtl/wb_commit.sv | 187 ++++++++++++++++++
 tb/tb_wb_commit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit -- write-back commit unit for the RV32I core.
//
// Merges results from the single-cycle ALU path and the multi-cycle load path
// into one registered register-file write port, and tracks how many writes
// are still outstanding for each architectural register so decode can stall
// on read-after-write hazards.
//
// Build option: define WB_BYPASS_EN to forward the committing value to decode
// (byp_hit*/byp_data*) and to let stall ignore a source whose last pending
// write is being committed this cycle. Without it the forwarding outputs are
// tied to 0 and stall is purely count based.
//
// Ports:
//   clk, reset                    rising-edge clock, async active-high reset
//   issue_valid/issue_rd          issuing instruction and its destination
//   issue_ready                   issue accepted (destination count below 3)
//   rs1, rs2                      decode-stage source registers
//   stall                         a source still has pending writes
//   alu_valid/alu_rd/alu_data     ALU result, always accepted
//   ld_valid/ld_ready/ld_rd/ld_data  load result handshake
//   write_en/write_reg/write_data registered register-file write port
//   byp_hit1/2, byp_data1/2       forwarding outputs
// -----------------------------------------------------------------------------
module wb_commit #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            write_en,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data1,
  output logic [XLEN-1:0] byp_data2
);

  localparam int PW = $clog2(LDQ_DEPTH);

  // ---------------------------------------------------------------------------
  // Load-result FIFO. Storage is not reset: clearing the pointers and fill
  // count is enough to discard in-flight entries.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ldq_data_mem [LDQ_DEPTH];
  logic [4:0]      ldq_rd_mem   [LDQ_DEPTH];
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [PW:0]     fill_reg;
  logic            ldq_full, ldq_empty, ldq_push, ldq_pop;

  assign ldq_full  = (fill_reg == (PW+1)'(LDQ_DEPTH));
  assign ldq_empty = (fill_reg == '0);
  // Readiness depends only on the current fill level, so a drain in the same
  // cycle does not open a slot until the next cycle.
  assign ld_ready  = !ldq_full;
  assign ldq_push  = ld_valid && !ldq_full;
  // The ALU always wins the commit slot; the head waits behind it.
  assign ldq_pop   = !alu_valid && !ldq_empty;

  always_ff @(posedge clk) begin
    if (ldq_push) begin
      ldq_data_mem[wr_ptr_reg] <= ld_data;
      ldq_rd_mem[wr_ptr_reg]   <= ld_rd;
    end
  end

  // Power-of-two depth: the pointers wrap naturally at their width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (ldq_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (ldq_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({ldq_push, ldq_pop})
        2'b10:   fill_reg <= fill_reg + (PW+1)'(1);
        2'b01:   fill_reg <= fill_reg - (PW+1)'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Commit register
  // ---------------------------------------------------------------------------
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            write_en_reg;
  logic [4:0]      write_reg_reg;
  logic [XLEN-1:0] write_data_reg;

  assign sel_valid = alu_valid || !ldq_empty;
  assign sel_rd    = alu_valid ? alu_rd   : ldq_rd_mem[rd_ptr_reg];
  assign sel_data  = alu_valid ? alu_data : ldq_data_mem[rd_ptr_reg];

  // An x0 result still takes the commit slot and updates write_reg/data, but
  // never raises write_en, so the register file and scoreboard ignore it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en_reg   <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
    end else begin
      write_en_reg <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        write_reg_reg  <= sel_rd;
        write_data_reg <= sel_data;
      end
    end
  end

  assign write_en   = write_en_reg;
  assign write_reg  = write_reg_reg;
  assign write_data = write_data_reg;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard: a 2-bit counter per register, x0 fixed at 0.
  // ---------------------------------------------------------------------------
  logic [31:0][1:0] cnt_reg, cnt_next;
  logic             issue_inc;

  assign issue_ready = (issue_rd == 5'd0) || (cnt_reg[issue_rd] != 2'd3);
  assign issue_inc   = issue_valid && issue_ready && (issue_rd != 5'd0);

  assign cnt_next[0] = 2'd0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
      logic inc_hit, dec_hit;
      assign inc_hit = issue_inc && (issue_rd == 5'(gi));
      assign dec_hit = write_en_reg && (write_reg_reg == 5'(gi));
      // Simultaneous issue and commit cancel; decrementing an idle counter
      // (a commit nobody scoreboarded) leaves it at zero.
      assign cnt_next[gi] =
        (inc_hit && !dec_hit)                            ? cnt_reg[gi] + 2'd1 :
        (dec_hit && !inc_hit && cnt_reg[gi] != 2'd0)    ? cnt_reg[gi] - 2'd1 :
                                                           cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and forwarding
  // ---------------------------------------------------------------------------
  logic src1_busy, src2_busy;

  assign src1_busy = (rs1 != 5'd0) && (cnt_reg[rs1] != 2'd0);
  assign src2_busy = (rs2 != 5'd0) && (cnt_reg[rs2] != 2'd0);

`ifdef WB_BYPASS_EN
  assign byp_hit1  = write_en_reg && (write_reg_reg == rs1) && (rs1 != 5'd0);
  assign byp_hit2  = write_en_reg && (write_reg_reg == rs2) && (rs2 != 5'd0);
  assign byp_data1 = write_data_reg;
  assign byp_data2 = write_data_reg;
  // When the only outstanding write is the one on the port right now, decode
  // can take it from the bypass instead of waiting.
  assign stall = (src1_busy && !(cnt_reg[rs1] == 2'd1 && byp_hit1)) ||
                 (src2_busy && !(cnt_reg[rs2] == 2'd1 && byp_hit2));
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
  assign stall     = src1_busy || src2_busy;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit -- self-checking bench for wb_commit: directed scenarios plus a
// randomized run compared against a queue/array reference model.
// -----------------------------------------------------------------------------
module tb_wb_commit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = '0;
  logic            issue_ready;
  logic [4:0]      rs1 = '0, rs2 = '0;
  logic            stall;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [4:0]      ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            write_en;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic            byp_hit1, byp_hit2;
  logic [XLEN-1:0] byp_data1, byp_data2;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_commit #(.XLEN(XLEN), .LDQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1-2 time units later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    issue_rd = 5'd17; rs1 = 5'd3; rs2 = 5'd31;
    #1;
    $display("reset: idle after reset");
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b want 0", write_en); end
    n_cmp++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg: got %0d want 0", write_reg); end
    n_cmp++; if (write_data !== 32'h0) begin n_fail++; $display("FAIL reset_write_data: got %h want 0", write_data); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_byp_hit: got %b%b want 00", byp_hit1, byp_hit2); end
    tick();
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL idle_write_en: got %b want 0", write_en); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_commit();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd5;
    $display("alu: issue x5");
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL alu_stall_pending: got %b want 1", stall); end
    $display("alu: result x5 = deadbeef");
    tick();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL alu_write_en: got %b want 1", write_en); end
    n_cmp++; if (write_reg !== 5'd5) begin n_fail++; $display("FAIL alu_write_reg: got %0d want 5", write_reg); end
    n_cmp++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_write_data: got %h want deadbeef", write_data); end
    // Count is still 1 until the commit edge; bypass may hide it.
    n_cmp++; if (stall !== !BYPASS_ON) begin n_fail++; $display("FAIL alu_stall_commit: got %b want %b", stall, !BYPASS_ON); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall_after: got %b want 0", stall); end
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL alu_write_en_after: got %b want 0", write_en); end
    n_cmp++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_write_data_hold: got %h want deadbeef", write_data); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_collision();
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid = 1'b1;  ld_rd = 5'd4;  ld_data = 32'h22;
    #1;
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ld_ready: got %b want 1", ld_ready); end
    $display("collision: alu x3=11, load x4=22");
    tick();
    idle_inputs();
    n_cmp++; if (write_en !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h11)
      begin n_fail++; $display("FAIL coll_first: got en=%b x%0d=%h want en=1 x3=11", write_en, write_reg, write_data); end
    tick();
    n_cmp++; if (write_en !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h22)
      begin n_fail++; $display("FAIL coll_second: got en=%b x%0d=%h want en=1 x4=22", write_en, write_reg, write_data); end
    tick();
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL coll_idle: got %b want 0", write_en); end

    // Fill the FIFO behind continuous ALU traffic.
    for (int i = 0; i < DEPTH + 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(32'h100 + i);
      ld_valid = 1'b1;  ld_rd = 5'(6 + i);   ld_data = 32'(32'h30 + i);
      #1;
      n_cmp++; if (ld_ready !== (i < DEPTH))
        begin n_fail++; $display("FAIL fill_ld_ready[%0d]: got %b want %b", i, ld_ready, i < DEPTH); end
      $display("fill: alu x%0d, load x%0d offered", alu_rd, ld_rd);
      tick();
      n_cmp++; if (write_en !== 1'b1 || write_reg !== 5'(20 + i))
        begin n_fail++; $display("FAIL fill_alu_commit[%0d]: got en=%b x%0d want en=1 x%0d", i, write_en, write_reg, 20 + i); end
    end
    idle_inputs();
    #1;
    // Full and draining this cycle: still not ready.
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ld_ready: got %b want 0", ld_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_cmp++; if (write_en !== 1'b1 || write_reg !== 5'(6 + i) || write_data !== 32'(32'h30 + i))
        begin n_fail++; $display("FAIL drain[%0d]: got en=%b x%0d=%h want en=1 x%0d=%h", i, write_en, write_reg, write_data, 6 + i, 32'h30 + i); end
      n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready[%0d]: got %b want 1", i, ld_ready); end
    end
    tick();
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", write_en); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_accept[%0d]: got %b want 1", i, issue_ready); end
      $display("sat: issue x9 #%0d", i);
      tick();
    end
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full: got %b want 0", issue_ready); end
    issue_rd = 5'd10;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_other: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    $display("sat: commit x9");
    tick();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_before_dec: got %b want 0", issue_ready); end
    tick();
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_restored: got %b want 1", issue_ready); end
    rs1 = 5'd10;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_x10_pending: got %b want 1", stall); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_x0();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    rs1 = 5'd0;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_issue_ready: got %b want 1", issue_ready); end
    $display("x0: issue x0, alu x0 = ffffffff");
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL x0_write_en: got %b want 0", write_en); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall); end
    n_cmp++; if (byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL x0_byp_hit1: got %b want 0", byp_hit1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hCAFE0008;
    $display("bypass: commit x8 = cafe0008");
    tick();
    alu_valid = 1'b0;
    rs2 = 5'd8; rs1 = 5'd0;
    #1;
    n_cmp++; if (byp_hit2 !== BYPASS_ON) begin n_fail++; $display("FAIL byp_hit2: got %b want %b", byp_hit2, BYPASS_ON); end
    n_cmp++; if (byp_data2 !== (BYPASS_ON ? 32'hCAFE0008 : 32'h0))
      begin n_fail++; $display("FAIL byp_data2: got %h want %h", byp_data2, BYPASS_ON ? 32'hCAFE0008 : 32'h0); end
    n_cmp++; if (stall !== !BYPASS_ON) begin n_fail++; $display("FAIL byp_stall: got %b want %b", stall, !BYPASS_ON); end
    n_cmp++; if (byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL byp_hit1_x0: got %b want 0", byp_hit1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(i);
      ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'h77;
      tick();
    end
    idle_inputs();
    rs1 = 5'd12; issue_rd = 5'd12;
    #1;
    n_cmp++; if (stall !== 1'b1 || write_en !== 1'b1 || ld_ready !== 1'b0)
      begin n_fail++; $display("FAIL arst_pre: got stall=%b en=%b ldr=%b want 1 1 0", stall, write_en, ld_ready); end
    #1;
    reset = 1'b1;
    $display("arst: reset asserted between edges");
    #1;
    n_cmp++; if (write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'h0)
      begin n_fail++; $display("FAIL arst_commit: got en=%b x%0d=%h want cleared", write_en, write_reg, write_data); end
    n_cmp++; if (ld_ready !== 1'b1 || stall !== 1'b0)
      begin n_fail++; $display("FAIL arst_state: got ldr=%b stall=%b want 1 0", ld_ready, stall); end
    #1;
    reset = 1'b0;
    tick();
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL arst_dropped: got %b want 0", write_en); end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against a reference model: per-register pending counts in
  // an int array, load results in a queue, commit port as plain variables.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ld_t;

  task automatic test_random();
    int              m_cnt [32];
    ld_t             m_q [$];
    ld_t             item;
    logic            m_we;
    logic [4:0]      m_wr;
    logic [XLEN-1:0] m_wd;
    logic            e_ir, e_lr, e_h1, e_h2, e_st;
    logic [XLEN-1:0] e_bd1, e_bd2;
    logic            b1, b2;
    bit              inc, dec;
    apply_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_we = 1'b0; m_wr = '0; m_wd = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 1) == 1);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      #1;

      e_ir = (issue_rd == 0) || (m_cnt[issue_rd] < 3);
      e_lr = (m_q.size() < DEPTH);
      e_h1 = BYPASS_ON && m_we && (m_wr == rs1) && (rs1 != 0);
      e_h2 = BYPASS_ON && m_we && (m_wr == rs2) && (rs2 != 0);
      e_bd1 = BYPASS_ON ? m_wd : '0;
      e_bd2 = BYPASS_ON ? m_wd : '0;
      b1 = (rs1 != 0) && (m_cnt[rs1] > 0) && !(m_cnt[rs1] == 1 && e_h1);
      b2 = (rs2 != 0) && (m_cnt[rs2] > 0) && !(m_cnt[rs2] == 1 && e_h2);
      e_st = b1 || b2;

      n_cmp++; if (issue_ready !== e_ir) begin n_fail++; $display("FAIL rnd_issue_ready @%0d: got %b want %b", cyc, issue_ready, e_ir); end
      n_cmp++; if (ld_ready !== e_lr) begin n_fail++; $display("FAIL rnd_ld_ready @%0d: got %b want %b", cyc, ld_ready, e_lr); end
      n_cmp++; if (stall !== e_st) begin n_fail++; $display("FAIL rnd_stall @%0d: got %b want %b", cyc, stall, e_st); end
      n_cmp++; if (byp_hit1 !== e_h1 || byp_hit2 !== e_h2)
        begin n_fail++; $display("FAIL rnd_byp_hit @%0d: got %b%b want %b%b", cyc, byp_hit1, byp_hit2, e_h1, e_h2); end
      n_cmp++; if (byp_data1 !== e_bd1 || byp_data2 !== e_bd2)
        begin n_fail++; $display("FAIL rnd_byp_data @%0d: got %h/%h want %h/%h", cyc, byp_data1, byp_data2, e_bd1, e_bd2); end

      // Advance the model across the coming edge.
      for (int r = 1; r < 32; r++) begin
        inc = issue_valid && e_ir && (issue_rd == r);
        dec = m_we && (m_wr == r);
        if (inc && !dec) m_cnt[r]++;
        else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
      end
      if (alu_valid) begin
        m_we = (alu_rd != 0); m_wr = alu_rd; m_wd = alu_data;
      end else if (m_q.size() > 0) begin
        item = m_q.pop_front();
        m_we = (item.rd != 0); m_wr = item.rd; m_wd = item.data;
      end else begin
        m_we = 1'b0;
      end
      if (ld_valid && e_lr) begin
        item.rd = ld_rd; item.data = ld_data;
        m_q.push_back(item);
      end

      tick();
      n_cmp++; if (write_en !== m_we || write_reg !== m_wr || write_data !== m_wd)
        begin n_fail++; $display("FAIL rnd_commit @%0d: got en=%b x%0d=%h want en=%b x%0d=%h", cyc, write_en, write_reg, write_data, m_we, m_wr, m_wd); end
      if (m_we) $display("rnd %0d: commit x%0d = %h", cyc, m_wr, m_wd);
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_alu_commit();
    test_collision();
    test_saturation();
    test_x0();
    test_bypass();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case a scenario ever stops advancing time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
